// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense scheduler.
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DISPENSE,
      WAIT_DONE,
      CHANGE
   } state_t;

   localparam logic [1:0] CH_ITEM1 = 2'b01;
   localparam logic [1:0] CH_ITEM2 = 2'b10;

   localparam logic [3:0] COIN5  = 4'b0101;
   localparam logic [3:0] COIN10 = 4'b1010;

   // Default prices line up with a single coin of each denomination.
   localparam logic [3:0] DEF_PRICE1 = COIN10;
   localparam logic [3:0] DEF_PRICE2 = COIN5;

   function automatic logic choice_ok(input logic [1:0] choice);
      return (choice == CH_ITEM1) || (choice == CH_ITEM2);
   endfunction

   function automatic logic [3:0] price_of(input logic [1:0] choice,
                                           input logic [3:0] p1,
                                           input logic [3:0] p2);
      logic [3:0] p;
      p = 4'd0;
      if (choice == CH_ITEM1) p = p1;
      else if (choice == CH_ITEM2) p = p2;
      return p;
   endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin pick: first valid panel at or after ptr, wrapping.
module vend_rr_arbiter #(
   parameter int unsigned N  = 2,
   parameter int unsigned GW = 1
) (
   input  logic [N-1:0]  valid,
   input  logic [GW-1:0] ptr,
   output logic [GW-1:0] winner,
   output logic          any_valid
);

   always_comb begin
      int unsigned idx;
      logic [N-1:0] sh;
      winner    = '0;
      any_valid = 1'b0;
      idx       = 0;
      sh        = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= N) idx = idx - N;
         sh = valid >> idx;
         if (!any_valid && sh[0]) begin
            any_valid = 1'b1;
            winner    = GW'(idx);
         end
      end
   end

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Shares one dispenser and change unit among NUM_PANELS panels, round-robin.
// Optional dispenser watchdog with refund: define VEND_DISP_TIMEOUT_EN.
module vend_dispense_scheduler
   import vend_pkg::*;
#(
   parameter int unsigned NUM_PANELS = 2,
   parameter logic [3:0]  PRICE1     = DEF_PRICE1,
   parameter logic [3:0]  PRICE2     = DEF_PRICE2,
   parameter int unsigned TIMEOUT    = 16,
   localparam int unsigned GW        = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_PANELS-1:0]   req_valid,
   input  logic [2*NUM_PANELS-1:0] req_choice,
   input  logic [4*NUM_PANELS-1:0] req_credit,
   output logic [NUM_PANELS-1:0]   req_ready,
   output logic [NUM_PANELS-1:0]   reject,
   output logic                    disp_start,
   output logic [1:0]              disp_item,
   input  logic                    disp_done,
   output logic [3:0]              change,
   output logic                    change_valid,
   output logic                    busy,
   output logic [GW-1:0]           grant_id,
   output logic                    fault
);

   state_t                state_q, state_d;
   logic [GW-1:0]         ptr_q, ptr_d, win_q, win_d, wrap_ptr, arb_win;
   logic                  arb_any;
   logic [1:0]            choice_q, choice_d, disp_item_d;
   logic [3:0]            credit_q, credit_d, chg_q, chg_d, change_d, price;
   logic [NUM_PANELS-1:0] req_ready_d, reject_d;
   logic                  disp_start_d, change_valid_d, busy_d;

   vend_rr_arbiter #(.N(NUM_PANELS), .GW(GW)) u_arb (
      .valid     (req_valid),
      .ptr       (ptr_q),
      .winner    (arb_win),
      .any_valid (arb_any)
   );

   assign price    = price_of(choice_q, PRICE1, PRICE2);
   assign wrap_ptr = (32'(win_q) == NUM_PANELS - 1) ? '0 : win_q + GW'(1);
   assign grant_id = win_q;

`ifdef VEND_DISP_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        fault_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         fault <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         fault <= fault_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = |32'(TIMEOUT);
   assign fault          = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      win_d          = win_q;
      choice_d       = choice_q;
      credit_d       = credit_q;
      chg_d          = chg_q;
      disp_item_d    = disp_item;
      req_ready_d    = '0;
      reject_d       = '0;
      disp_start_d   = 1'b0;
      change_d       = '0;
      change_valid_d = 1'b0;
`ifdef VEND_DISP_TIMEOUT_EN
      fault_d        = 1'b0;
      cnt_d          = (state_q == WAIT_DONE) ? cnt_q + 16'd1 : '0;
`endif
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               win_d       = arb_win;
               choice_d    = 2'(req_choice >> (2 * 32'(arb_win)));
               credit_d    = 4'(req_credit >> (4 * 32'(arb_win)));
               req_ready_d = NUM_PANELS'(1) << arb_win;
               state_d     = CHECK;
            end
         end
         CHECK: begin
            if (!choice_ok(choice_q) || (credit_q < price)) begin
               reject_d = NUM_PANELS'(1) << win_q;
               ptr_d    = wrap_ptr;
               state_d  = IDLE;
            end else begin
               chg_d        = credit_q - price;
               disp_start_d = 1'b1;
               disp_item_d  = choice_q;
               state_d      = DISPENSE;
            end
         end
         DISPENSE: state_d = WAIT_DONE;
         WAIT_DONE: begin
            // Completion takes priority over a same-cycle timeout.
            if (disp_done) begin
               ptr_d = wrap_ptr;
               if (chg_q != 4'd0) begin
                  change_d       = chg_q;
                  change_valid_d = 1'b1;
                  state_d        = CHANGE;
               end else begin
                  state_d = IDLE;
               end
            end
`ifdef VEND_DISP_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               fault_d = 1'b1;
               chg_d   = credit_q;
               ptr_d   = wrap_ptr;
               if (credit_q != 4'd0) begin
                  change_d       = credit_q;
                  change_valid_d = 1'b1;
                  state_d        = CHANGE;
               end else begin
                  state_d = IDLE;
               end
            end
`endif
         end
         CHANGE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) disp_item_d = '0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         win_q        <= '0;
         choice_q     <= '0;
         credit_q     <= '0;
         chg_q        <= '0;
         req_ready    <= '0;
         reject       <= '0;
         disp_start   <= 1'b0;
         disp_item    <= '0;
         change       <= '0;
         change_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         win_q        <= win_d;
         choice_q     <= choice_d;
         credit_q     <= credit_d;
         chg_q        <= chg_d;
         req_ready    <= req_ready_d;
         reject       <= reject_d;
         disp_start   <= disp_start_d;
         disp_item    <= disp_item_d;
         change       <= change_d;
         change_valid <= change_valid_d;
         busy         <= busy_d;
      end
   end

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Directed bench for vend_dispense_scheduler; timeout steps run when
// VEND_DISP_TIMEOUT_EN is defined (TIMEOUT=8).
module tb_vend_dispense_scheduler;

   localparam int unsigned NP = 2;
`ifdef VEND_DISP_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 16;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [NP-1:0]   req_valid;
   logic [2*NP-1:0] req_choice;
   logic [4*NP-1:0] req_credit;
   logic [NP-1:0]   req_ready;
   logic [NP-1:0]   reject;
   logic            disp_start;
   logic [1:0]      disp_item;
   logic            disp_done;
   logic [3:0]      change;
   logic            change_valid;
   logic            busy;
   logic [0:0]      grant_id;
   logic            fault;
   logic [3:0]      chg_seen;

   int n_cmp = 0;
   int n_bad = 0;

   vend_dispense_scheduler #(.NUM_PANELS(NP), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_choice   (req_choice),
      .req_credit   (req_credit),
      .req_ready    (req_ready),
      .reject       (reject),
      .disp_start   (disp_start),
      .disp_item    (disp_item),
      .disp_done    (disp_done),
      .change       (change),
      .change_valid (change_valid),
      .busy         (busy),
      .grant_id     (grant_id),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic [1:0] ch, input logic [3:0] cr);
      req_choice[2*p +: 2] = ch;
      req_credit[4*p +: 4] = cr;
   endtask

   // which: 0 any req_ready, 1 disp_start, 2 not busy
   task automatic wait_ev(input string tag, input int which);
      int n;
      bit hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 40) begin
         step();
         n++;
         case (which)
            0:       hit = |req_ready;
            1:       hit = disp_start;
            default: hit = !busy;
         endcase
      end
      if (!hit) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s: observed timeout after %0d cycles expected event", tag, n);
      end
   endtask

   task automatic do_txn(input logic [NP-1:0] v, output logic [3:0] chg);
      req_valid = v;
      wait_ev("txn_ready", 0);
      req_valid = '0;
      wait_ev("txn_start", 1);
      step();
      disp_done = 1'b1;
      step();
      disp_done = 1'b0;
      chg = change_valid ? change : 4'd0;
      wait_ev("txn_idle", 2);
   endtask

   function automatic logic [15:0] all_outs();
      return 16'({req_ready, reject, disp_start, disp_item, change, change_valid,
                  busy, grant_id, fault});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      req_choice = '0;
      req_credit = '0;
      disp_done  = 1'b0;
      #12;
      chk("reset_outputs", all_outs(), 16'h0);
      reset = 1'b0;
      step();

      // 1: panel0 item1 exact credit, done 3 cycles after start
      set_req(0, 2'b01, 4'd10);
      req_valid = 2'b01;
      step();
      chk("t1_ready", 16'(req_ready), 16'h1);
      chk("t1_busy", 16'(busy), 16'h1);
      chk("t1_grant", 16'(grant_id), 16'h0);
      req_valid = '0;
      step();
      chk("t1_start", 16'({disp_start, disp_item}), 16'h5);
      step();
      chk("t1_start_pulse", 16'(disp_start), 16'h0);
      step();
      step();
      disp_done = 1'b1;
      step();
      disp_done = 1'b0;
      chk("t1_no_change", 16'({change_valid, change}), 16'h0);
      chk("t1_idle", 16'(busy), 16'h0);

      // 2: panel1 item2 credit 10 -> change 5
      set_req(1, 2'b10, 4'd10);
      req_valid = 2'b10;
      step();
      chk("t2_ready", 16'(req_ready), 16'h2);
      req_valid = '0;
      step();
      chk("t2_start", 16'({disp_start, disp_item}), 16'h6);
      step();
      disp_done = 1'b1;
      step();
      disp_done = 1'b0;
      chk("t2_change", 16'({change_valid, change}), 16'h15);
      chk("t2_grant", 16'(grant_id), 16'h1);
      step();
      chk("t2_after", 16'({change_valid, change, busy}), 16'h0);

      // 3: both panels held valid -> grants alternate 0,1,0,1
      set_req(0, 2'b01, 4'd10);
      req_valid = 2'b11;
      disp_done = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_ev("t3_wait", 0);
         chk($sformatf("t3_grant%0d", k), 16'(req_ready), (k % 2 == 1) ? 16'h2 : 16'h1);
      end
      req_valid = '0;
      wait_ev("t3_idle", 2);
      disp_done = 1'b0;

      // 4: rejects (short credit, bad choice), pointer advances each time
      set_req(0, 2'b01, 4'd5);
      req_valid = 2'b01;
      step();
      chk("t4a_ready", 16'(req_ready), 16'h1);
      req_valid = '0;
      step();
      chk("t4a_reject", 16'({reject, disp_start, busy}), 16'h4);
      step();
      chk("t4a_reject_pulse", 16'(reject), 16'h0);
      set_req(0, 2'b11, 4'd10);
      req_valid = 2'b01;
      step();
      chk("t4b_ready", 16'(req_ready), 16'h1);
      req_valid = '0;
      step();
      chk("t4b_reject", 16'({reject, disp_start}), 16'h2);
      set_req(0, 2'b01, 4'd10);
      set_req(1, 2'b10, 4'd15);
      req_valid = 2'b11;
      step();
      chk("t4_ptr_panel1", 16'(req_ready), 16'h2);
      req_valid = '0;
      step();
      step();
      disp_done = 1'b1;
      step();
      disp_done = 1'b0;
      chk("t4_change15", 16'({change_valid, change}), 16'h1a);
      step();

      // 5: reset during WAIT_DONE aborts; pointer restarts at 0
      set_req(0, 2'b01, 4'd15);
      do_txn(2'b01, chg_seen);
      chk("t5_setup_change", 16'(chg_seen), 16'h5);
      req_valid = 2'b01;
      step();
      req_valid = '0;
      step();
      step();
      chk("t5_busy_wait", 16'(busy), 16'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_reset", all_outs(), 16'h0);
      step();
      reset     = 1'b0;
      disp_done = 1'b1;
      step();
      disp_done = 1'b0;
      chk("t5_done_ignored", 16'({busy, change_valid, disp_start}), 16'h0);
      set_req(1, 2'b10, 4'd10);
      req_valid = 2'b11;
      step();
      chk("t5_restart_panel0", 16'(req_ready), 16'h1);
      req_valid = '0;
      wait_ev("t5_start", 1);
      step();
      disp_done = 1'b1;
      step();
      disp_done = 1'b0;
      wait_ev("t5_idle", 2);
      chk("t5_fault", 16'(fault), 16'h0);

`ifdef VEND_DISP_TIMEOUT_EN
      // 6: no disp_done -> fault after 8 WAIT_DONE cycles, full refund
      set_req(1, 2'b10, 4'd10);
      req_valid = 2'b10;
      step();
      chk("t6_ready", 16'(req_ready), 16'h2);
      req_valid = '0;
      step();
      step();
      repeat (7) step();
      chk("t6_no_fault_yet", 16'({fault, change_valid}), 16'h0);
      step();
      chk("t6_fault", 16'(fault), 16'h1);
      chk("t6_refund", 16'({change_valid, change}), 16'h1a);
      step();
      chk("t6_after", 16'({fault, change_valid, busy}), 16'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
